exc_ctrl: RTL and testbench

- Sequences the CP0 coprocessor and the 5-stage pipeline around exceptions, interrupts and eret.
- Sits beside CP0 at the M (commit) stage: picks the victim instruction/PC, gates CP0 writes, synchronises external HWInt, and issues flush plus PC redirect to the handler or to EPC.
- A registered 3-state FSM gives every trap and eret a fixed one-cycle redirect bubble.

---
 rtl/exc_ctrl_pkg.sv | 18 +
 rtl/exc_ctrl_hwint_sync.sv | 27 ++
 rtl/exc_ctrl.sv | 123 ++++++++++++
 tb/tb_exc_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exc_ctrl_pkg.sv
// Shared constants and types for the exception/eret sequencer beside CP0.
package exc_ctrl_pkg;

  // Fetch address of the common exception handler.
  localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h0000_4180;

  // Cause code for an interrupt; also what CP0 sees when no M-stage code applies.
  localparam logic [4:0]  EXCCODE_INT = 5'd0;

  // Redirect sequencer states. Each trap and each eret spends exactly one
  // cycle in its redirect state before returning to RUN.
  typedef enum logic [1:0] {
    RUN  = 2'd0,
    TRAP = 2'd1,
    ERET = 2'd2
  } state_t;

endpackage

// File: rtl/exc_ctrl_hwint_sync.sv
// Multi-flop synchroniser for the asynchronous device interrupt lines.
module exc_ctrl_hwint_sync #(
  parameter int W      = 6,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] raw,
  output logic [W-1:0] synced
);

  logic [STAGES-1:0][W-1:0] sync_q;

  // Shift the raw lines through STAGES flops; stage 0 is the metastability catcher.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the value from before the edge, giving a true shift chain.
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], raw};
    end
  end

  assign synced = sync_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt/eret sequencer at the M (commit) stage. Picks the victim
// PC for CP0, gates CP0 writes, synchronises HWInt and drives flush/redirect.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC  = DEFAULT_HANDLER_PC,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hwint_raw,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic        m_bd,
  input  logic [4:0]  m_exccode,
  input  logic        m_is_eret,
  input  logic        m_is_mtc0,
  input  logic        e_valid,
  input  logic [31:0] e_pc,
  input  logic        e_bd,
  input  logic [31:0] d_pc,
  input  logic [1:0]  cp0_request,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  cp0_hwint,
  output logic [31:0] cp0_vpc,
  output logic        cp0_bd,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_we,
  output logic        cp0_exlclr,
  output logic        flush_all,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc
);

  state_t      state_q, state_d;
  logic [31:0] epc_q;
  logic [31:0] victim_pc;
  logic        victim_bd;
  logic        in_run;
  logic        any_request;

  exc_ctrl_hwint_sync #(
    .W      (6),
    .STAGES (SYNC_STAGES)
  ) u_hwint_sync (
    .clk    (clk),
    .reset  (reset),
    .raw    (hwint_raw),
    .synced (cp0_hwint)
  );

  assign in_run      = (state_q == RUN);
  assign any_request = |cp0_request;

  // Victim is the oldest real instruction: M, else E, else the D-stage PC.
  always_comb begin
    victim_pc = d_pc;
    victim_bd = 1'b0;
    if (m_valid) begin
      victim_pc = m_pc;
      victim_bd = m_bd;
    end else if (e_valid) begin
      victim_pc = e_pc;
      victim_bd = e_bd;
    end
  end

  // CP0 derives EPC = BD ? VPC : VPC-4, so pre-bias VPC to land EPC on the
  // branch PC for a delay-slot victim and on the victim PC otherwise.
  assign cp0_vpc     = victim_bd ? (victim_pc - 32'd4) : (victim_pc + 32'd4);
  assign cp0_bd      = victim_bd;
  assign cp0_exccode = (in_run && m_valid) ? m_exccode : EXCCODE_INT;
  // A trapping instruction must not commit its mtc0.
  assign cp0_we      = m_is_mtc0 & m_valid & in_run & ~any_request;

  // State register plus a copy of EPC taken one cycle behind CP0, so an mtc0
  // EPC immediately before eret is already visible when ERET redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      epc_q   <= '0;
    end else begin
      state_q <= state_d;
      epc_q   <= cp0_epc;
    end
  end

  // Next-state and redirect outputs; requests beat eret, and are ignored
  // while already redirecting.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    flush_all   = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    cp0_exlclr  = 1'b0;
    case (state_q)
      RUN: begin
        if (any_request) begin
          state_d = TRAP;
        end else if (m_valid && m_is_eret) begin
          cp0_exlclr = 1'b1;
          state_d    = ERET;
        end
      end
      TRAP: begin
        flush_all   = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = HANDLER_PC;
        state_d     = RUN;
      end
      ERET: begin
        flush_all   = 1'b1;
        pc_redirect = 1'b1;
        redirect_pc = epc_q;
        state_d     = RUN;
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed-vector bench for exc_ctrl; expected values are hand-computed.
module tb_exc_ctrl;
  import exc_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  hwint_raw;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_bd;
  logic [4:0]  m_exccode;
  logic        m_is_eret;
  logic        m_is_mtc0;
  logic        e_valid;
  logic [31:0] e_pc;
  logic        e_bd;
  logic [31:0] d_pc;
  logic [1:0]  cp0_request;
  logic [31:0] cp0_epc;
  logic [5:0]  cp0_hwint;
  logic [31:0] cp0_vpc;
  logic        cp0_bd;
  logic [4:0]  cp0_exccode;
  logic        cp0_we;
  logic        cp0_exlclr;
  logic        flush_all;
  logic        pc_redirect;
  logic [31:0] redirect_pc;

  int vectors     = 0;
  int miscompares = 0;

  exc_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .hwint_raw   (hwint_raw),
    .m_valid     (m_valid),
    .m_pc        (m_pc),
    .m_bd        (m_bd),
    .m_exccode   (m_exccode),
    .m_is_eret   (m_is_eret),
    .m_is_mtc0   (m_is_mtc0),
    .e_valid     (e_valid),
    .e_pc        (e_pc),
    .e_bd        (e_bd),
    .d_pc        (d_pc),
    .cp0_request (cp0_request),
    .cp0_epc     (cp0_epc),
    .cp0_hwint   (cp0_hwint),
    .cp0_vpc     (cp0_vpc),
    .cp0_bd      (cp0_bd),
    .cp0_exccode (cp0_exccode),
    .cp0_we      (cp0_we),
    .cp0_exlclr  (cp0_exlclr),
    .flush_all   (flush_all),
    .pc_redirect (pc_redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 ns later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    m_valid     = 1'b0;
    m_pc        = '0;
    m_bd        = 1'b0;
    m_exccode   = '0;
    m_is_eret   = 1'b0;
    m_is_mtc0   = 1'b0;
    e_valid     = 1'b0;
    e_pc        = '0;
    e_bd        = 1'b0;
    d_pc        = '0;
    cp0_request = '0;
  endtask

  task automatic check_state_run(input string tag);
    check(tag, {30'd0, dut.state_q}, {30'd0, RUN});
  endtask

  initial begin
    reset     = 1'b1;
    hwint_raw = 6'h3F;
    cp0_epc   = '0;
    idle_inputs();

    // Reset held two cycles with all interrupt lines high.
    next_cycle();
    next_cycle();
    settle();
    check("rst_hwint",    {26'd0, cp0_hwint}, 32'h0);
    check("rst_flush",    {31'd0, flush_all}, 32'h0);
    check("rst_redir",    {31'd0, pc_redirect}, 32'h0);
    check("rst_rpc",      redirect_pc, 32'h0);
    check("rst_we",       {31'd0, cp0_we}, 32'h0);
    check("rst_exlclr",   {31'd0, cp0_exlclr}, 32'h0);
    check("rst_exccode",  {27'd0, cp0_exccode}, 32'h0);
    check("rst_vpc",      cp0_vpc, 32'h4);
    check_state_run("rst_state");

    // Release: HWInt must appear after exactly two rising edges.
    reset = 1'b0;
    next_cycle();
    settle();
    check("sync_edge1", {26'd0, cp0_hwint}, 32'h0);
    next_cycle();
    settle();
    check("sync_edge2", {26'd0, cp0_hwint}, 32'h3F);
    hwint_raw = 6'h00;

    // Exception in M, with mtc0 set: write must be suppressed.
    next_cycle();
    m_valid     = 1'b1;
    m_pc        = 32'h0000_3010;
    m_exccode   = 5'd10;
    m_is_mtc0   = 1'b1;
    cp0_request = 2'b10;
    settle();
    check("exc_vpc",     cp0_vpc, 32'h0000_3014);
    check("exc_bd",      {31'd0, cp0_bd}, 32'h0);
    check("exc_code",    {27'd0, cp0_exccode}, 32'd10);
    check("exc_we",      {31'd0, cp0_we}, 32'h0);
    check("exc_noflush", {31'd0, flush_all}, 32'h0);
    // TRAP cycle: M still shows code 10 and mtc0, both must be masked.
    next_cycle();
    cp0_request = 2'b00;
    settle();
    check("trap_flush",   {31'd0, flush_all}, 32'h1);
    check("trap_redir",   {31'd0, pc_redirect}, 32'h1);
    check("trap_rpc",     redirect_pc, 32'h0000_4180);
    check("trap_exccode", {27'd0, cp0_exccode}, 32'h0);
    check("trap_we",      {31'd0, cp0_we}, 32'h0);
    next_cycle();
    idle_inputs();
    settle();
    check("post_trap_flush", {31'd0, flush_all}, 32'h0);
    check_state_run("post_trap_state");

    // Interrupt while M is a bubble: victim from E, delay slot.
    next_cycle();
    e_valid     = 1'b1;
    e_pc        = 32'h0000_3020;
    e_bd        = 1'b1;
    m_exccode   = 5'd7;
    cp0_request = 2'b01;
    settle();
    check("int_vpc",  cp0_vpc, 32'h0000_301C);
    check("int_bd",   {31'd0, cp0_bd}, 32'h1);
    check("int_code", {27'd0, cp0_exccode}, 32'h0);
    next_cycle();
    idle_inputs();
    settle();
    check("int_trap_flush", {31'd0, flush_all}, 32'h1);
    check("int_trap_rpc",   redirect_pc, 32'h0000_4180);

    // Last-resort victim from D.
    next_cycle();
    d_pc = 32'h0000_5000;
    settle();
    check("d_vpc", cp0_vpc, 32'h0000_5004);
    check("d_bd",  {31'd0, cp0_bd}, 32'h0);
    check("d_idle_flush", {31'd0, flush_all}, 32'h0);

    // mtc0 EPC followed by eret; the bench plays CP0 and updates EPC.
    next_cycle();
    idle_inputs();
    m_valid   = 1'b1;
    m_pc      = 32'h0000_3030;
    m_is_mtc0 = 1'b1;
    settle();
    check("mtc0_we",     {31'd0, cp0_we}, 32'h1);
    check("mtc0_exlclr", {31'd0, cp0_exlclr}, 32'h0);
    next_cycle();
    cp0_epc   = 32'h0000_3100;
    m_pc      = 32'h0000_3034;
    m_is_mtc0 = 1'b0;
    m_is_eret = 1'b1;
    settle();
    check("eret_exlclr", {31'd0, cp0_exlclr}, 32'h1);
    check("eret_we",     {31'd0, cp0_we}, 32'h0);
    check("eret_noflush", {31'd0, flush_all}, 32'h0);
    // ERET cycle: a request arriving now must be ignored.
    next_cycle();
    idle_inputs();
    cp0_request = 2'b01;
    settle();
    check("eret_flush",  {31'd0, flush_all}, 32'h1);
    check("eret_redir",  {31'd0, pc_redirect}, 32'h1);
    check("eret_rpc",    redirect_pc, 32'h0000_3100);
    check("eret_exl0",   {31'd0, cp0_exlclr}, 32'h0);
    next_cycle();
    cp0_request = 2'b00;
    settle();
    check("ign_req_flush", {31'd0, flush_all}, 32'h0);
    check_state_run("ign_req_state");

    // eret and request together: request wins.
    next_cycle();
    m_valid     = 1'b1;
    m_pc        = 32'h0000_3040;
    m_is_eret   = 1'b1;
    cp0_request = 2'b01;
    settle();
    check("race_exlclr", {31'd0, cp0_exlclr}, 32'h0);
    next_cycle();
    idle_inputs();
    settle();
    check("race_flush", {31'd0, flush_all}, 32'h1);
    check("race_rpc",   redirect_pc, 32'h0000_4180);

    // Reset during TRAP abandons it.
    next_cycle();
    cp0_request = 2'b10;
    next_cycle();
    cp0_request = 2'b00;
    reset       = 1'b1;
    settle();
    check("rtrap_flush_pre", {31'd0, flush_all}, 32'h1);
    next_cycle();
    settle();
    check("rtrap_redir", {31'd0, pc_redirect}, 32'h0);
    check("rtrap_flush", {31'd0, flush_all}, 32'h0);
    check_state_run("rtrap_state");
    reset = 1'b0;

    next_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
